// File: rtl/router_input_arbiter_if.sv
// Handshake bundle between the five router input ports, the input arbiter
// and the routing decision unit.
//   master: upstream/driver side (drives in_*, out_ready)
//   slave : arbiter side (drives in_ready, out_*)
interface router_input_arbiter_if #(
    parameter int unsigned WIDTH_PACKAGE = 33,
    parameter int unsigned NUM_PORTS     = 5
);
    logic [NUM_PORTS*WIDTH_PACKAGE-1:0] in_data;
    logic [NUM_PORTS-1:0]               in_valid;
    logic [NUM_PORTS-1:0]               in_ready;
    logic [WIDTH_PACKAGE-1:0]           out_data;
    logic                               out_valid;
    logic                               out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/router_input_arbiter.sv
// Round-robin input arbiter in front of the NoC router decision unit.
// Picks one packet per cycle from up/left/down/right/pe_mem (index 0..4),
// registers it in a single output slot and offers it on a valid/ready port.
// A drained slot may be refilled on the same edge, so load sustains 1 packet/cycle.
// Optional build macro ARB_STATS_EN adds saturating per-port grant counters
// and the grant_cnt output port.
module router_input_arbiter #(
    parameter int unsigned WIDTH_PACKAGE = 33,
    parameter int unsigned NUM_PORTS     = 5
`ifdef ARB_STATS_EN
    ,
    parameter int unsigned CNT_W         = 16
`endif
) (
    input logic                   clk,
    input logic                   reset,
    router_input_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] grant_cnt
`endif
);
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {StEmpty, StFull} slot_state_e;

    slot_state_e              state_q;
    logic [WIDTH_PACKAGE-1:0] out_data_q;
    logic [PTR_W-1:0]         rr_ptr_q;

    logic                     can_load;
    logic                     grant_found;
    logic [PTR_W-1:0]         grant_idx;
    logic                     load;
    logic [NUM_PORTS-1:0]     in_ready_d;
    logic [WIDTH_PACKAGE-1:0] sel_data;

    assign can_load = (state_q == StEmpty) || bus.out_ready;
    // Reset blocks any handshake so upstream keeps its packet.
    assign load     = can_load && grant_found && !reset;

    // Round-robin scan starting just after the last granted port.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            idx  = (32'(rr_ptr_q) + off) % NUM_PORTS;
            cand = PTR_W'(idx);
            if (!grant_found && bus.in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot accept for the winner, and the winning packet mux.
    always_comb begin
        in_ready_d = '0;
        sel_data   = '0;
        if (load) begin
            in_ready_d[grant_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_data = bus.in_data[i*WIDTH_PACKAGE +: WIDTH_PACKAGE];
            end
        end
    end

    // Output slot FSM: load on handshake, drain when accepted and nothing replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            rr_ptr_q   <= PTR_W'(NUM_PORTS - 1);
        end else if (load) begin
            state_q    <= StFull;
            out_data_q <= sel_data;
            rr_ptr_q   <= grant_idx;
        end else if (state_q == StFull && bus.out_ready) begin
            state_q    <= StEmpty;
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == StFull);

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_PORTS];

    // Per-port grant counters; saturate at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (load) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (grant_idx == PTR_W'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Flatten counters onto the packed output port.
    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif
endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed bench for router_input_arbiter: accepted packets are pushed to a
// scoreboard queue and popped when the output slot presents them.
module tb_router_input_arbiter;
    localparam int unsigned W = 33;
    localparam int unsigned N = 5;
`ifdef ARB_STATS_EN
    localparam int unsigned CW = 2;
`endif

    logic clk;
    logic reset;

    router_input_arbiter_if #(.WIDTH_PACKAGE(W), .NUM_PORTS(N)) bus ();

`ifdef ARB_STATS_EN
    logic [N*CW-1:0] grant_cnt;
    router_input_arbiter #(.WIDTH_PACKAGE(W), .NUM_PORTS(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .grant_cnt (grant_cnt)
    );
`else
    router_input_arbiter #(.WIDTH_PACKAGE(W), .NUM_PORTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] pkt [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] valid, input logic ready);
        bus.in_valid  = valid;
        bus.out_ready = ready;
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = pkt[i];
    endtask

    // Check the slot; when a packet is expected, compare it with the scoreboard head.
    task automatic expect_out(input string tag, input logic exp_valid);
        logic [W-1:0] exp_pkt;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(exp_valid));
        if (exp_valid) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_underflow"}, 64'(sb_q.size()), 64'd1);
            end else begin
                exp_pkt = sb_q.pop_front();
                check({tag, "_data"}, 64'(bus.out_data), 64'(exp_pkt));
            end
        end
    endtask

    initial begin
        logic [W-1:0] held;
        for (int i = 0; i < N; i++) pkt[i] = {4'(i + 8), 29'(i * 1000 + 17)};
        load_data();
        reset = 1'b1;
        drive(5'b11111, 1'b1);

        // Reset: no accepts even with every port requesting.
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        check("rst_ready2", 64'(bus.in_ready), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);

        // Idle after reset.
        reset = 1'b0;
        drive(5'b00000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("idle_ready", 64'(bus.in_ready), 64'd0);
            check("idle_valid", 64'(bus.out_valid), 64'd0);
            tick();
        end

        // Single request on port 2.
        pkt[2] = {4'd7, 29'd0};
        load_data();
        drive(5'b00100, 1'b1);
        check("single_ready", 64'(bus.in_ready), 64'b00100);
        sb_q.push_back({4'd7, 29'd0});
        tick();
        drive(5'b00000, 1'b1);
        expect_out("single", 1'b1);
        tick();
        expect_out("single_drain", 1'b0);

        // All ports requesting from reset: strict 0..4 rotation with wrap.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) pkt[i] = {4'(i + 8), 29'(i * 1000 + 17)};
        load_data();
        drive(5'b11111, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("rr_ready_%0d", k), 64'(bus.in_ready), 64'(1 << (k % N)));
            sb_q.push_back(pkt[k % N]);
            tick();
            expect_out($sformatf("rr_out_%0d", k), 1'b1);
        end
        drive(5'b00000, 1'b1);
        tick();
        expect_out("rr_drain", 1'b0);

        // Backpressure: hold port 0 packet while ports 1 and 3 wait.
        drive(5'b00001, 1'b1);
        check("bp_load_ready", 64'(bus.in_ready), 64'b00001);
        sb_q.push_back(pkt[0]);
        tick();
        expect_out("bp_load", 1'b1);
        held = pkt[0];
        drive(5'b01010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", 64'(bus.in_ready), 64'd0);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_data", 64'(bus.out_data), 64'(held));
            tick();
        end
        drive(5'b01010, 1'b1);
        check("bp_rel_ready1", 64'(bus.in_ready), 64'b00010);
        sb_q.push_back(pkt[1]);
        tick();
        expect_out("bp_rel1", 1'b1);
        drive(5'b01000, 1'b1);
        check("bp_rel_ready3", 64'(bus.in_ready), 64'b01000);
        sb_q.push_back(pkt[3]);
        tick();
        expect_out("bp_rel3", 1'b1);
        drive(5'b00000, 1'b1);
        tick();
        expect_out("bp_drain", 1'b0);

        // Reset while full and requested: slot discarded, port 0 wins after release.
        drive(5'b11111, 1'b1);
        check("mr_fill_ready", 64'(bus.in_ready), 64'b10000);
        sb_q.push_back(pkt[4]);
        tick();
        expect_out("mr_fill", 1'b1);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("mr_rst_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("mr_rst_valid", 64'(bus.out_valid), 64'd0);
        reset = 1'b0;
        drive(5'b11111, 1'b1);
        check("mr_first_ready", 64'(bus.in_ready), 64'b00001);
        sb_q.push_back(pkt[0]);
        tick();
        expect_out("mr_first", 1'b1);
        drive(5'b00000, 1'b1);
        tick();
        expect_out("mr_drain", 1'b0);

`ifdef ARB_STATS_EN
        // Port 4 granted five times with 2-bit counters: saturates at 3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(5'b10000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("st_ready", 64'(bus.in_ready), 64'b10000);
            sb_q.push_back(pkt[4]);
            tick();
            expect_out("st_out", 1'b1);
        end
        drive(5'b00000, 1'b1);
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("st_cnt_%0d", i), 64'(grant_cnt[i*CW +: CW]),
                  (i == 4) ? 64'd3 : 64'd0);
        end
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
